// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Wide enough for any practical instruction width; users slice [DATA_W-1:0].
  localparam int NOP_MAX_W = 256;
  localparam logic [NOP_MAX_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one write port, one synchronous read port, contents never reset.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Loads an instruction stream into local storage, then serves 1-cycle-latency fetches.
// Optional build macro: LOAD_CHECKSUM_EN adds a running XOR of accepted words.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              LoadInstructions,
  input  logic [DATA_W-1:0] Instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic [ADDR_W:0]   load_count,
  output logic              full,
  output logic              load_err,
  output logic              run,
  output logic [DATA_W-1:0] checksum
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              fv_q, oob_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              enter_load, accept, drop, fetch_go;

  always_ff @(posedge clk) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (LoadInstructions)  state_d = LOAD;
      LOAD:    if (!LoadInstructions) state_d = RUN;
      RUN:     if (LoadInstructions)  state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    run         = 1'b0;
    if (state_q == LOAD && !full) instr_ready = 1'b1;
    if (state_q == RUN)           run         = 1'b1;
  end

  assign full       = (count_q == (ADDR_W+1)'(DEPTH));
  assign enter_load = (state_d == LOAD) && (state_q != LOAD);
  assign accept     = instr_valid && instr_ready;
  assign drop       = (state_q == LOAD) && instr_valid && full;
  assign fetch_go   = (state_q == RUN) && fetch_en;

  // Entering LOAD wins; no word can be accepted on that cycle since state_q is not LOAD.
  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (enter_load) begin
      wptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        wptr_d  = wptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
      end
      if (drop) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      fv_q    <= fetch_go;
      oob_q   <= ({1'b0, fetch_addr} >= count_q);
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (Instruction),
    .re_i    (fetch_go),
    .raddr_i (fetch_addr),
    .rdata_o (ram_rdata)
  );

  // Unloaded addresses read as NOP; the mux also keeps fetch_data at zero when idle.
  assign fetch_data  = (fv_q && !oob_q) ? ram_rdata : NOP_WORD[DATA_W-1:0];
  assign fetch_valid = fv_q;
  assign load_count  = count_q;
  assign load_err    = err_q;

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (enter_load)  checksum_d = '0;
    else if (accept) checksum_d = checksum_q ^ Instruction;
  end

  always_ff @(posedge clk) begin
    if (!Reset) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = NOP_WORD[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a DEPTH=64 instance (A) and a DEPTH=4 instance (B).
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, li, iv, fe;
  logic [31:0] ins_a, ins_b;
  logic [5:0]  fa_a;
  logic [1:0]  fa_b;
  wire  [1:0]  rdy, fv, rn, fl, er;
  wire  [31:0] fd_a, fd_b, cs_a, cs_b;
  wire  [6:0]  lc_a;
  wire  [2:0]  lc_b;

  imem_loader #(.DATA_W(32), .DEPTH(64)) dut_a (
    .clk(clk), .Reset(rst_n[0]), .LoadInstructions(li[0]), .Instruction(ins_a),
    .instr_valid(iv[0]), .instr_ready(rdy[0]), .fetch_en(fe[0]), .fetch_addr(fa_a),
    .fetch_data(fd_a), .fetch_valid(fv[0]), .load_count(lc_a), .full(fl[0]),
    .load_err(er[0]), .run(rn[0]), .checksum(cs_a)
  );

  imem_loader #(.DATA_W(32), .DEPTH(4)) dut_b (
    .clk(clk), .Reset(rst_n[1]), .LoadInstructions(li[1]), .Instruction(ins_b),
    .instr_valid(iv[1]), .instr_ready(rdy[1]), .fetch_en(fe[1]), .fetch_addr(fa_b),
    .fetch_data(fd_b), .fetch_valid(fv[1]), .load_count(lc_b), .full(fl[1]),
    .load_err(er[1]), .run(rn[1]), .checksum(cs_b)
  );

  int ntot = 0;
  int nbad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: mode 0=idle 1=loading 2=running.
  int          m_mode [2] = '{0, 0};
  int          m_cnt  [2] = '{0, 0};
  bit          m_err  [2] = '{0, 0};
  bit          m_fv   [2] = '{0, 0};
  logic [31:0] m_fd   [2] = '{0, 0};
  logic [31:0] m_cs   [2] = '{0, 0};
  logic [31:0] m_mem  [2][64];
  int          dep    [2] = '{64, 4};

  task automatic model_step(input int i);
    logic        r, l, v, f;
    int          a;
    logic [31:0] w;
    r = rst_n[i]; l = li[i]; v = iv[i]; f = fe[i];
    a = (i == 0) ? int'(fa_a) : int'(fa_b);
    w = (i == 0) ? ins_a : ins_b;
    if (!r) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_cs[i] = 0; m_fv[i] = 0; m_fd[i] = 0;
    end else begin
      m_fv[i] = (m_mode[i] == 2) && f;
      m_fd[i] = (m_fv[i] && a < m_cnt[i]) ? m_mem[i][a] : 32'h0;
      if (m_mode[i] == 1) begin
        if (v) begin
          if (m_cnt[i] < dep[i]) begin
            m_mem[i][m_cnt[i]] = w;
            m_cnt[i]++;
`ifdef LOAD_CHECKSUM_EN
            m_cs[i] = m_cs[i] ^ w;
`endif
          end else begin
            m_err[i] = 1'b1;
          end
        end
        if (!l) m_mode[i] = 2;
      end else if (l) begin
        m_mode[i] = 1; m_cnt[i] = 0; m_err[i] = 0; m_cs[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        string p;
        p = (i == 0) ? "A" : "B";
        chk({p, ".run"},         rn[i],  64'(m_mode[i] == 2));
        chk({p, ".instr_ready"}, rdy[i], 64'(m_mode[i] == 1 && m_cnt[i] != dep[i]));
        chk({p, ".full"},        fl[i],  64'(m_cnt[i] == dep[i]));
        chk({p, ".load_err"},    er[i],  64'(m_err[i]));
        chk({p, ".load_count"},  (i == 0) ? 64'(lc_a) : 64'(lc_b), 64'(m_cnt[i]));
        chk({p, ".fetch_valid"}, fv[i],  64'(m_fv[i]));
        chk({p, ".checksum"},    (i == 0) ? cs_a : cs_b, m_cs[i]);
        if (m_fv[i]) chk({p, ".fetch_data"}, (i == 0) ? fd_a : fd_b, m_fd[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] words [11];
  logic [31:0] cs_exp;

  initial begin
    words[0] = 32'h200101A7;
    words[1] = 32'h2002005C;
    for (int k = 2; k < 11; k++) words[k] = 32'hA5000000 | 32'(k * 17);
`ifdef LOAD_CHECKSUM_EN
    cs_exp = 32'h000301FB;
`else
    cs_exp = 32'h0;
`endif
    rst_n = 2'b00; li = '0; iv = '0; fe = '0;
    ins_a = '0; ins_b = '0; fa_a = '0; fa_b = '0;

    tick();
    chk_on = 1'b1;
    chk("rst.run", rn[0], 0);
    chk("rst.instr_ready", rdy[0], 0);
    chk("rst.load_count", lc_a, 0);
    chk("rst.fetch_valid", fv[0], 0);
    chk("rst.load_err", er[0], 0);
    chk("rst.fetch_data", fd_a, 0);
    rst_n = 2'b11;

    // A: load 11 words, LoadInstructions drops with the last one
    li[0] = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) begin
      iv[0] = 1'b1; ins_a = words[k];
      if (k == 10) li[0] = 1'b0;
      tick();
    end
    iv[0] = 1'b0;
    chk("A.lit.run", rn[0], 1);
    chk("A.lit.count11", lc_a, 11);

    fe[0] = 1'b1; fa_a = 6'd0;
    tick();
    chk("A.lit.fv0", fv[0], 1);
    chk("A.lit.fd0", fd_a, 32'h200101A7);
    fa_a = 6'd1;
    tick();
    chk("A.lit.fd1", fd_a, 32'h2002005C);
    fa_a = 6'd20;
    tick();
    chk("A.lit.fd20", fd_a, 32'h0);
    chk("A.lit.fv20", fv[0], 1);
    fe[0] = 1'b0;
    tick();
    chk("A.lit.fv_idle", fv[0], 0);

    // B: overfill a 4-deep store
    li[1] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      iv[1] = 1'b1; ins_b = words[k];
      tick();
    end
    iv[1] = 1'b0;
    chk("B.lit.full", fl[1], 1);
    chk("B.lit.ready", rdy[1], 0);
    chk("B.lit.err", er[1], 1);
    chk("B.lit.count4", lc_b, 4);
    li[1] = 1'b0;
    tick();
    chk("B.lit.run", rn[1], 1);
    fe[1] = 1'b1; fa_b = 2'd3;
    tick();
    chk("B.lit.fd3", fd_b, words[3]);
    fe[1] = 1'b0; li[1] = 1'b1;
    tick();
    chk("B.lit.err_clr", er[1], 0);
    li[1] = 1'b0;
    tick();

    // A: reset mid-load, fetch requests during LOAD/IDLE ignored, then reload
    li[0] = 1'b1; fe[0] = 1'b1; fa_a = 6'd0;
    tick();
    for (int k = 0; k < 3; k++) begin
      iv[0] = 1'b1; ins_a = words[k + 2];
      tick();
    end
    iv[0] = 1'b0; rst_n[0] = 1'b0;
    tick();
    chk("A.lit.midrst_run", rn[0], 0);
    chk("A.lit.midrst_cnt", lc_a, 0);
    chk("A.lit.midrst_rdy", rdy[0], 0);
    rst_n[0] = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      iv[0] = 1'b1; ins_a = words[k];
      if (k == 1) li[0] = 1'b0;
      tick();
    end
    iv[0] = 1'b0;
    chk("A.lit.reload_cnt", lc_a, 2);
    chk("A.lit.checksum", cs_a, cs_exp);
    fa_a = 6'd1;
    tick();
    chk("A.lit.reload_fd1", fd_a, 32'h2002005C);
    fa_a = 6'd0; rst_n[0] = 1'b0;
    tick();
    chk("A.lit.rst_kills_fetch", fv[0], 0);
    rst_n[0] = 1'b1; fe[0] = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 64, instruction store depth in words.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), fetch address width.
REQ-004 Port clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port Reset  in  1  synchronous, active-low reset.
REQ-006 Port LoadInstructions  in  1  load-mode request; level-sensitive.
REQ-007 Port Instruction  in  DATA_W  instruction word offered for loading.
REQ-008 Port instr_valid  in  1  Instruction is valid this cycle.
REQ-009 Port instr_ready  out  1  loader accepts Instruction this cycle.
REQ-010 Port fetch_en  in  1  fetch request.
REQ-011 Port fetch_addr  in  ADDR_W  word address of the fetch.
REQ-012 Port fetch_data  out  DATA_W  fetched instruction word.
REQ-013 Port fetch_valid  out  1  fetch_data is valid this cycle.
REQ-014 Port load_count  out  ADDR_W+1  number of words loaded.
REQ-015 Port full  out  1  load_count equals DEPTH.
REQ-016 Port load_err  out  1  sticky flag; a write was attempted while full.
REQ-017 Port run  out  1  the CPU may fetch and execute.
REQ-018 Port checksum  out  DATA_W  running XOR of loaded words.

Function
REQ-019 The loader SHALL implement a state machine with states IDLE, LOAD and RUN.
REQ-020 Transitions SHALL be: IDLE->LOAD when LoadInstructions=1; LOAD->RUN when LoadInstructions=0; RUN->LOAD when LoadInstructions=1; IDLE otherwise holds.
REQ-021 On entering LOAD, the write pointer, load_count, load_err and checksum SHALL clear to 0.
REQ-022 instr_ready SHALL equal (state==LOAD && !full); it SHALL be a registered-state decode with no dependency on instr_valid.
REQ-023 A word SHALL be accepted on any cycle where instr_valid && instr_ready.
- On acceptance, it SHALL be written to mem[wptr], and wptr and load_count SHALL each increment by 1.
REQ-024 instr_valid=1 in LOAD while full SHALL drop the word and set load_err, which holds until the next LOAD entry or reset.
REQ-025 If LoadInstructions falls in the same cycle as an accepted word, the word SHALL be stored and counted, and the state SHALL still move to RUN.
REQ-026 In RUN, fetch_en=1 SHALL produce fetch_data=mem[fetch_addr] and fetch_valid=1 on the next cycle (1-cycle latency).
- Back-to-back fetches SHALL be supported, one per cycle.
REQ-027 A fetch with fetch_addr >= load_count SHALL return all-zero fetch_data (NOP), with fetch_valid=1.
REQ-028 Outside RUN, fetch_en SHALL be ignored and fetch_valid SHALL be 0.
REQ-029 run SHALL equal (state==RUN).

Reset
REQ-030 While Reset=0 at a clock edge, the loader SHALL set:
- state=IDLE;
- wptr=0, load_count=0;
- full=0, load_err=0, instr_ready=0;
- fetch_valid=0, fetch_data=0;
- checksum=0, run=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 A reset during LOAD or RUN SHALL abandon the operation immediately; a fetch pending at the time of reset SHALL NOT produce fetch_valid.

Configuration
REQ-033 With LOAD_CHECKSUM_EN defined, checksum SHALL be XOR-updated with every accepted word.
REQ-034 Without LOAD_CHECKSUM_EN, checksum SHALL be constant 0 and no checksum register SHALL exist.

Structure
REQ-035 Package imem_pkg SHALL hold:
- the state typedef (IDLE/LOAD/RUN);
- the NOP_WORD constant (all zeros).
REQ-036 Sub-module imem_ram SHALL hold the storage: one write port and one synchronous read port, parametrised by DATA_W and DEPTH.

Verification
REQ-037 Drive Reset=0 for 1 cycle -> run=0, instr_ready=0, load_count=0, fetch_valid=0, load_err=0.
REQ-038 Load 11 words starting 0x200101A7, 0x2002005C, then drop LoadInstructions -> run=1 next cycle, load_count=11.
- Then fetch_addr=0 -> fetch_data=0x200101A7 with fetch_valid one cycle later.
REQ-039 Fetch addresses 0 then 1 on consecutive cycles -> 0x200101A7 then 0x2002005C on consecutive cycles.
- Then fetch_addr=20 -> fetch_data=0.
REQ-040 With DEPTH=4, offer 5 words -> 4 accepted, full=1, instr_ready=0, load_err=1, load_count=4.
REQ-041 Assert Reset mid-load after 3 words -> state IDLE, load_count=0.
- Reload 2 words -> load_count=2.
REQ-042 With LOAD_CHECKSUM_EN defined, load 0x200101A7 and 0x2002005C -> checksum=0x000301FB.
